spi_master_periph: RTL
======================

# spi_master_periph

Bus-mapped SPI master for the user SPI port (spi0). Occupies register space 0xFF10–0xFF13 alongside uart0 and is selected when bus address bits [7:4] equal 4'h1. It contains its own clock divider and mode-0 shift engine, independent of the reserved SPI. The CPU drives transfers one byte at a time through the DATA register.

## Interface
Parameters:
- DIV_RESET, 8'd25: reset value of the DIV register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous and active-low.
- bus_address  in  2  register offset (bus_address_out[1:0]).
- bus_data_tx  in  8  write data from CPU.
- bus_data_rx  out  8  read data to CPU, combinational from bus_address.
- bus_read  in  1  read strobe, already gated by the address decode.
- bus_write  in  1  write strobe, already gated by the address decode.
- bus_wait  out  1  stall; while high, the CPU holds its strobe and address.
- spi_clk  out  1  SPI clock, idle low.
- spi_mosi  out  1  SPI data out.
- spi_miso  in  1  SPI data in.
- spi_ce_n  out  1  chip enable, active-low.

## Operation
Registers:
- 0 DATA
  - Write: starts an 8-bit transfer of bus_data_tx.
  - Read: returns the last received byte and clears rx_valid.
- 1 STATUS (read-only): bit0 busy, bit1 rx_valid, other bits 0. Writes are ignored.
- 2 CTRL: bit0 ce. When ce=1, spi_ce_n=0. Other bits read 0.
- 3 DIV: half-period of spi_clk is DIV+1 clk cycles.

Bus rules:
- A write is accepted on any rising edge where bus_write=1 and bus_wait=0.
- bus_wait=1 only when bus_write=1, bus_address=0 and the engine is busy. It falls in the cycle the engine returns to IDLE, and the write is accepted on that edge.
- Reads never stall.

Engine:
- States: IDLE, LOW, HIGH. Mode 0, MSB first. A 3-bit bit counter and an 8-bit half-period counter.
- IDLE → LOW on DATA accept:
  - Load the shift register.
  - Latch DIV into the working divider; DIV writes mid-transfer affect only the next transfer.
  - busy=1. spi_mosi=bit7.
- LOW → HIGH after DIV+1 cycles:
  - spi_clk=1.
  - spi_miso is sampled into the shift register LSB on this edge.
- HIGH → LOW after DIV+1 cycles, if the bit counter is not 7:
  - spi_clk=0, shift left, spi_mosi=next bit, increment the bit counter.
- HIGH → IDLE after DIV+1 cycles, if the bit counter is 7:
  - spi_clk=0, rx_data gets the shift register, rx_valid=1, busy=0.
  - spi_mosi holds its last value.
- CTRL.ce is applied immediately, even mid-transfer. Firmware owns CE framing.

Reset values: spi_clk 0, spi_mosi 0, spi_ce_n 1, bus_wait 0, busy 0, rx_valid 0, rx_data 8'h00, CTRL 8'h00, DIV DIV_RESET, state IDLE.

## Timing
- Write to DATA accepted at edge N:
  - busy and spi_mosi (bit7) are valid after edge N.
  - First spi_clk rise at edge N+(DIV+1).
  - Transfer completes at edge N+16·(DIV+1): busy=0 and rx_valid=1 from then.
- DIV=0 gives spi_clk = clk/2; the whole transfer takes 16 cycles.
- Back-to-back DATA write while busy:
  - Stalls until the completing edge M.
  - Accepted at M, so the next transfer starts with zero idle cycles. Its first LOW phase begins after M.
- Simultaneous DATA read and transfer completion in one cycle: the read returns the old rx_data, and rx_valid ends at 1 (set wins over clear).
- Asynchronous reset mid-transfer: all state returns to reset values immediately. spi_clk goes low and spi_ce_n goes high with no clock edge required.
- Reads of STATUS reflect register state at the start of the cycle; there is no bypass.

## Structure
- Shared package holds:
  - register offsets (DATA=0, STATUS=1, CTRL=2, DIV=3);
  - STATUS bit indices (BUSY=0, RX_VALID=1);
  - the default divider 8'd25;
  - the engine state encoding.
- One sub-module, spi_shifter:
  - owns the state machine, both counters, the shift register, spi_clk and spi_mosi;
  - interface: start, tx byte, divider, busy, done pulse, rx byte.
- The top level keeps the register file, bus decode and wait generation.
- Top-level integration: decode bus_address_out[7:4]==4'h1 and mux bus_data_rx/bus_wait in the register path.

## Test plan
- Reset: assert rst_n=0 mid-transfer → spi_clk=0, spi_ce_n=1, STATUS=8'h00 and DIV reads 8'd25 with no clock edge.
- Loopback (spi_mosi tied to spi_miso), DIV=0, CTRL=1, write DATA=8'hA5 → exactly 8 spi_clk rises, MOSI sequence 1,0,1,0,0,1,0,1, busy clears 16 cycles after accept, DATA read =8'hA5, STATUS then =8'h00.
- DIV=3, MISO driven 8'h3C by the bench model → spi_clk high and low phases of 4 cycles each, transfer length 64 cycles, DATA read =8'h3C.
- Write DATA=8'h11 then immediately DATA=8'h22 → bus_wait high until the first completion, second transfer starts on the same edge, MOSI shows 8'h11 then 8'h22 contiguously.
- Write DIV=8'd7 during a DIV=0 transfer → current transfer keeps a 1-cycle half-period, next transfer uses 8 cycles.
- Read DATA on the exact completion cycle → returns the previous byte and STATUS rx_valid=1 afterwards; writes to STATUS leave it unchanged.

Source files
------------

// File: rtl/spi_master_periph_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_periph_pkg
//  Description : Shared definitions for the spi0 bus-mapped SPI master:
//                register offsets, STATUS bit positions, default divider and
//                the shift-engine state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_master_periph_pkg;

  // Register offsets within the 4-byte window
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  // STATUS bit positions
  localparam int STAT_BUSY     = 0;
  localparam int STAT_RX_VALID = 1;

  // Default half-period divider (half-period = DIV+1 clk cycles)
  localparam logic [7:0] DIV_DEFAULT = 8'd25;

  // Shift engine states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_t;

endpackage : spi_master_periph_pkg
`default_nettype wire

// File: rtl/spi_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_shifter
//  Description : Mode-0, MSB-first 8-bit SPI shift engine with its own
//                half-period counter. A start is taken in IDLE or on the very
//                edge that completes the current byte, so back-to-back bytes
//                run with no idle gap.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_shifter
  import spi_master_periph_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic [7:0] divider,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  spi_state_t r_state, w_state_n;
  logic [7:0] r_half_cnt, w_half_cnt_n;
  logic [2:0] r_bit_cnt, w_bit_cnt_n;
  logic [7:0] r_shreg, w_shreg_n;
  logic [7:0] r_wdiv, w_wdiv_n;
  logic       r_sclk, w_sclk_n;
  logic       r_mosi, w_mosi_n;

  logic       w_half_end;
  logic       w_load;

  assign w_half_end = (r_half_cnt == r_wdiv);
  // Completing edge: falling edge after the eighth rise
  assign done       = (r_state == ST_HIGH) && w_half_end && (r_bit_cnt == 3'd7);
  assign w_load     = start && ((r_state == ST_IDLE) || done);

  assign busy     = (r_state != ST_IDLE);
  assign rx_byte  = r_shreg;
  assign spi_clk  = r_sclk;
  assign spi_mosi = r_mosi;

  // Engine registers, cleared asynchronously so spi_clk drops without a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_half_cnt <= 8'd0;
      r_bit_cnt  <= 3'd0;
      r_shreg    <= 8'd0;
      r_wdiv     <= 8'd0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_half_cnt <= w_half_cnt_n;
      r_bit_cnt  <= w_bit_cnt_n;
      r_shreg    <= w_shreg_n;
      r_wdiv     <= w_wdiv_n;
      r_sclk     <= w_sclk_n;
      r_mosi     <= w_mosi_n;
    end
  end

  // Next-state logic. The shift register moves left on the rising edge while
  // capturing MISO into bit 0; MOSI is a separate flop updated from the new
  // bit 7 on the falling edge, so the outgoing bit is never overwritten by an
  // incoming one.
  always_comb begin
    w_state_n    = r_state;
    w_half_cnt_n = r_half_cnt;
    w_bit_cnt_n  = r_bit_cnt;
    w_shreg_n    = r_shreg;
    w_wdiv_n     = r_wdiv;
    w_sclk_n     = r_sclk;
    w_mosi_n     = r_mosi;

    if (w_load) begin
      w_state_n    = ST_LOW;
      w_half_cnt_n = 8'd0;
      w_bit_cnt_n  = 3'd0;
      w_shreg_n    = tx_byte;
      w_wdiv_n     = divider;
      w_sclk_n     = 1'b0;
      w_mosi_n     = tx_byte[7];
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_half_cnt_n = 8'd0;
        end
        ST_LOW: begin
          if (w_half_end) begin
            w_half_cnt_n = 8'd0;
            w_sclk_n     = 1'b1;
            w_shreg_n    = {r_shreg[6:0], spi_miso};
            w_state_n    = ST_HIGH;
          end else begin
            w_half_cnt_n = r_half_cnt + 8'd1;
          end
        end
        ST_HIGH: begin
          if (w_half_end) begin
            w_half_cnt_n = 8'd0;
            w_sclk_n     = 1'b0;
            if (r_bit_cnt == 3'd7) begin
              w_state_n = ST_IDLE;
            end else begin
              w_bit_cnt_n = r_bit_cnt + 3'd1;
              w_mosi_n    = r_shreg[7];
              w_state_n   = ST_LOW;
            end
          end else begin
            w_half_cnt_n = r_half_cnt + 8'd1;
          end
        end
        default: begin
          w_state_n = ST_IDLE;
          w_sclk_n  = 1'b0;
        end
      endcase
    end
  end

endmodule : spi_shifter
`default_nettype wire

// File: rtl/spi_master_periph.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_periph
//  Description : Bus-mapped SPI master (spi0) at 0xFF10-0xFF13. The system
//                decode (address[7:4] == 4'h1) gates bus_read/bus_write before
//                they reach this block; here only the 2-bit offset is seen.
//                Holds DATA/STATUS/CTRL/DIV, stalls DATA writes while a byte is
//                in flight and releases the stall on the completing edge.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_master_periph
  import spi_master_periph_pkg::*;
#(
  parameter logic [7:0] DIV_RESET = DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] bus_address,
  input  logic [7:0] bus_data_tx,
  output logic [7:0] bus_data_rx,
  input  logic       bus_read,
  input  logic       bus_write,
  output logic       bus_wait,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_ce_n
);

  logic       r_ce;
  logic [7:0] r_div;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;

  logic       w_busy;
  logic       w_done;
  logic [7:0] w_rx_byte;
  logic       w_accept;
  logic       w_start;
  logic       w_data_read;

  // A DATA write stalls only while a byte is in flight and not completing now
  assign bus_wait    = bus_write && (bus_address == REG_DATA) && w_busy && !w_done;
  assign w_accept    = bus_write && !bus_wait;
  assign w_start     = w_accept && (bus_address == REG_DATA);
  assign w_data_read = bus_read && (bus_address == REG_DATA);
  assign spi_ce_n    = ~r_ce;

  spi_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .tx_byte  (bus_data_tx),
    .divider  (r_div),
    .busy     (w_busy),
    .done     (w_done),
    .rx_byte  (w_rx_byte),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  // CTRL and DIV register writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ce  <= 1'b0;
      r_div <= DIV_RESET;
    end else if (w_accept) begin
      if (bus_address == REG_CTRL) r_ce  <= bus_data_tx[0];
      if (bus_address == REG_DIV)  r_div <= bus_data_tx;
    end
  end

  // Receive holding register; completion sets rx_valid and wins over a
  // same-cycle DATA read clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_done) begin
        r_rx_data  <= w_rx_byte;
        r_rx_valid <= 1'b1;
      end else if (w_data_read) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  // Read mux, purely from registered state
  always_comb begin
    bus_data_rx = 8'h00;
    case (bus_address)
      REG_DATA:   bus_data_rx = r_rx_data;
      REG_STATUS: begin
        bus_data_rx[STAT_BUSY]     = w_busy;
        bus_data_rx[STAT_RX_VALID] = r_rx_valid;
      end
      REG_CTRL:   bus_data_rx[0] = r_ce;
      REG_DIV:    bus_data_rx = r_div;
      default:    bus_data_rx = 8'h00;
    endcase
  end

endmodule : spi_master_periph
`default_nettype wire
